// File: rtl/frame_packet_queue.sv
// Store-and-forward frame FIFO: words become visible to the reader only once
// their frame's end_frame word has been written without any overflow.
module frame_packet_queue #(
    parameter int width_p    = 8,
    parameter int log2_els_p = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_req,
    input  logic [width_p-1:0] wr_data,
    input  logic               start_frame,
    input  logic               end_frame,
    output logic               full,
    input  logic               rd_req,
    output logic               empty,
    output logic [width_p-1:0] rd_data
);

    localparam int els_lp   = 1 << log2_els_p;
    localparam int ptr_w_lp = log2_els_p + 1;
    localparam logic [ptr_w_lp-1:0] depth_lp = ptr_w_lp'(els_lp);
    localparam logic [ptr_w_lp-1:0] one_lp   = ptr_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] zero_lp  = '0;

    logic [ptr_w_lp-1:0] rd_ptr;
    logic [ptr_w_lp-1:0] wr_ptr;
    logic [ptr_w_lp-1:0] commit_ptr;
    logic                in_frame;
    logic                drop;

    logic [width_p-1:0]  mem [els_lp];

    logic [ptr_w_lp-1:0] wr_base;
    logic [ptr_w_lp-1:0] wr_ptr_next;
    logic                frame_active;
    logic                has_space;
    logic                accept;
    logic                overflow;
    logic                drop_eff;
    logic                closing;
    logic                do_read;

    // A start_frame word rewinds to the last commit point, abandoning any
    // frame that never saw its end_frame.
    always_comb begin
        wr_base      = (wr_req && start_frame) ? commit_ptr : wr_ptr;
        frame_active = wr_req && (start_frame || in_frame);
        has_space    = (wr_base - rd_ptr) != depth_lp;
        accept       = frame_active && has_space;
        overflow     = frame_active && !has_space;
        wr_ptr_next  = accept ? (wr_base + one_lp) : wr_base;
        drop_eff     = (start_frame ? 1'b0 : drop) || overflow;
        closing      = frame_active && end_frame;
        do_read      = rd_req && !empty;
    end

    assign empty   = (rd_ptr == commit_ptr);
    assign full    = ((wr_ptr - rd_ptr) == depth_lp);
    assign rd_data = mem[rd_ptr[log2_els_p-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= zero_lp;
            wr_ptr     <= zero_lp;
            commit_ptr <= zero_lp;
            in_frame   <= 1'b0;
            drop       <= 1'b0;
        end else begin
            if (do_read) begin
                rd_ptr <= rd_ptr + one_lp;
            end
            if (closing) begin
                in_frame <= 1'b0;
                drop     <= 1'b0;
                // Any lost word poisons the whole frame, so roll back instead.
                if (!drop_eff) begin
                    wr_ptr     <= wr_ptr_next;
                    commit_ptr <= wr_ptr_next;
                end else begin
                    wr_ptr <= commit_ptr;
                end
            end else if (frame_active) begin
                in_frame <= 1'b1;
                drop     <= drop_eff;
                wr_ptr   <= wr_ptr_next;
            end
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_base[log2_els_p-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_frame_packet_queue.sv
// Scoreboard bench for frame_packet_queue: directed scenarios then random
// traffic, checked against a queue-based model of committed and pending words.
module tb_frame_packet_queue;

    localparam int W     = 8;
    localparam int L     = 3;
    localparam int DEPTH = 1 << L;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_req = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         start_frame = 1'b0;
    logic         end_frame = 1'b0;
    logic         rd_req = 1'b0;
    logic         full;
    logic         empty;
    logic [W-1:0] rd_data;

    frame_packet_queue #(.width_p(W), .log2_els_p(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .start_frame (start_frame),
        .end_frame   (end_frame),
        .full        (full),
        .rd_req      (rd_req),
        .empty       (empty),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: exp_q holds committed words in read order, pend holds the open frame.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pend[$];
    bit           m_in_frame = 1'b0;
    bit           m_drop = 1'b0;
    bit           m_pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: compares flags and popped data away from the rising edge, then
    // advances the model by what the coming edge should do.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            pend.delete();
            m_in_frame = 1'b0;
            m_drop     = 1'b0;
        end else begin
            check("empty", empty, exp_q.size() == 0);
            check("full", full, (exp_q.size() + pend.size()) == DEPTH);
            m_pop = rd_req && (exp_q.size() > 0);
            if (rd_req && !empty) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_data: got %0h, required nothing (queue empty)", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q[0]);
                    $display("[TB] pop %02h (expected %02h)", rd_data, exp_q[0]);
                end
            end
            if (wr_req) begin
                if (start_frame) begin
                    pend.delete();
                    m_in_frame = 1'b1;
                    m_drop     = 1'b0;
                end
                if (m_in_frame) begin
                    if ((exp_q.size() + pend.size()) < DEPTH) pend.push_back(wr_data);
                    else m_drop = 1'b1;
                    if (end_frame) begin
                        if (!m_drop) foreach (pend[i]) exp_q.push_back(pend[i]);
                        pend.delete();
                        m_in_frame = 1'b0;
                        m_drop     = 1'b0;
                    end
                end
            end
            if (m_pop) void'(exp_q.pop_front());
        end
    end

    task automatic cyc(input bit w, input bit s, input bit e, input logic [W-1:0] d, input bit r);
        wr_req      = w;
        start_frame = s;
        end_frame   = e;
        wr_data     = d;
        rd_req      = r;
        @(posedge clk);
        #1;
        wr_req      = 1'b0;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        rd_req      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_empty", empty, 1);
        check("reset_full", full, 0);
        rst = 1'b1;
        idle(1);

        // Three-word frame, then drain.
        cyc(1, 1, 0, 8'h11, 0);
        cyc(1, 0, 0, 8'h22, 0);
        cyc(1, 0, 1, 8'h33, 0);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0, 1);

        // Unterminated frame is discarded by the next start.
        cyc(1, 1, 0, 8'hAA, 0);
        cyc(1, 0, 0, 8'hBB, 0);
        idle(2);
        cyc(1, 1, 1, 8'h55, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, '0, 1);

        // Exactly full, stray write, pop, drain.
        for (int i = 1; i <= DEPTH; i++) cyc(1, i == 1, i == DEPTH, 8'(i), 0);
        cyc(1, 0, 0, 8'h09, 0);
        cyc(0, 0, 0, '0, 1);
        idle(1);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, '0, 1);

        // Oversized frame never commits.
        for (int i = 1; i <= 10; i++) cyc(1, i == 1, i == 10, 8'(8'h40 + i), 0);
        idle(2);

        // Single-word frames with concurrent pops across pointer wrap.
        for (int i = 0; i < 20; i++) cyc(i % 2 == 0, i % 2 == 0, i % 2 == 0, 8'(8'h80 + i), 1);
        idle(1);

        // Asynchronous reset mid-frame with committed data present.
        cyc(1, 1, 0, 8'h61, 0);
        cyc(1, 0, 1, 8'h62, 0);
        cyc(1, 1, 0, 8'h63, 0);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_empty", empty, 1);
        check("midreset_full", full, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 1, 1, 8'h7E, 0);
        cyc(0, 0, 0, '0, 1);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 25, 8'($urandom), $urandom_range(0, 99) < 40);
        end
        for (int i = 0; i < 2 * DEPTH; i++) cyc(0, 0, 0, '0, 1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
